shift_unit: RTL



---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_step.sv | 52 +++++
 rtl/shift_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the multi-mode sequential
//               shifter (mode and state encodings, mode field width).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int MODE_W = 3;

    // Shift mode encoding; codes 5..7 are reserved and pass data through.
    typedef enum logic [MODE_W-1:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    // True for the reserved mode codes, which skip the SHIFT state entirely.
    function automatic logic mode_is_reserved(input logic [MODE_W-1:0] mode);
        return (mode > 3'(SH_ROR));
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Purely combinational single-bit shift/rotate step. Produces
//               the next work value and the bit that leaves the word.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]      data,
    input  logic [MODE_W-1:0] mode,
    output logic [N-1:0]      next_data,
    output logic              out_bit
);

    // One-position move in the selected direction with the mode's fill rule.
    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        case (mode)
            SH_LSL: begin
                next_data = {data[N-2:0], 1'b0};
                out_bit   = data[N-1];
            end
            SH_LSR: begin
                next_data = {1'b0, data[N-1:1]};
                out_bit   = data[0];
            end
            SH_ASR: begin
                next_data = {data[N-1], data[N-1:1]};
                out_bit   = data[0];
            end
            SH_ROL: begin
                next_data = {data[N-2:0], data[N-1]};
                out_bit   = data[N-1];
            end
            SH_ROR: begin
                next_data = {data[0], data[N-1:1]};
                out_bit   = data[0];
            end
            default: begin
                next_data = data;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit
// Description : Multi-mode sequential shifter (LSL/LSR/ASR/ROL/ROR), one bit
//               position per clock, valid/ready on both request and result.
//               Optional macro SHIFT_CARRY_EN adds the registered out_carry
//               output holding the last departing bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_unit
    import shift_pkg::*;
#(
    parameter  int N = 8,
    localparam int A = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [A-1:0]      in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              busy
`ifdef SHIFT_CARRY_EN
    ,
    output logic              out_carry
`endif
);

    shift_state_e      r_state;
    shift_state_e      w_state_nxt;
    logic [N-1:0]      r_work;
    logic [MODE_W-1:0] r_mode;
    logic [A-1:0]      r_count;
    logic [N-1:0]      w_step_data;
    logic              w_step_bit;
    logic              w_accept;
    logic              w_skip;

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    assign in_ready  = (r_state == ST_IDLE) & rst_n;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_work;
    assign w_accept  = in_valid & in_ready;
    assign w_skip    = (in_amt == '0) | mode_is_reserved(in_mode);

    shift_step #(
        .N (N)
    ) u_step (
        .data      (r_work),
        .mode      (r_mode),
        .next_data (w_step_data),
        .out_bit   (w_step_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: zero amounts and reserved modes bypass SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == A'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Work register, latched mode and remaining-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_mode  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_work  <= in_data;
            r_mode  <= in_mode;
            r_count <= in_amt;
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_step_data;
            r_count <= r_count - 1'b1;
        end
    end

`ifdef SHIFT_CARRY_EN
    logic r_carry;

    assign out_carry = r_carry;

    // Carry tracks the bit leaving the word on each step; cleared on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_carry <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_carry <= w_step_bit;
        end
    end
`else
    logic w_unused_bit;

    assign w_unused_bit = w_step_bit;
`endif

endmodule
`default_nettype wire
